// File: rtl/writer_pkg.sv
// Shared definitions for the writeback stage.
//   op_t           : instruction class as decoded upstream
//   control_info_t : control word travelling with an instruction from execute
//                    into writeback (valid, write_rd, rd, pc, op, mem_byte_off)
//   is_load()      : true for the five load classes
package writer_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREG_DEF  = 32;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [3:0] {
    OP_ALU    = 4'd0,
    OP_LB     = 4'd1,
    OP_LH     = 4'd2,
    OP_LW     = 4'd3,
    OP_LBU    = 4'd4,
    OP_LHU    = 4'd5,
    OP_JAL    = 4'd6,
    OP_JALR   = 4'd7,
    OP_STORE  = 4'd8,
    OP_BRANCH = 4'd9
  } op_t;

  typedef struct packed {
    logic        valid;         // 0 = bubble
    logic        write_rd;      // instruction writes a destination register
    logic [4:0]  rd;            // destination register index
    logic [31:0] pc;            // word-addressed PC of the instruction
    op_t         op;            // instruction class
    logic [1:0]  mem_byte_off;  // low address bits of the memory access
  } control_info_t;

  function automatic logic is_load(input op_t op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/writer_load_formatter.sv
// Combinational load-lane selection and extension.
//   word_i    : raw block-memory read word
//   is_lb_i / is_lh_i / is_lbu_i / is_lhu_i : load class flags (none set = lw)
//   off_i     : byte offset within the word
//   result_o  : formatted load value
// Halfword loads use only off_i[1]; a misaligned half is silently truncated
// to the containing aligned half.
module load_formatter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic            is_lb_i,
  input  logic            is_lh_i,
  input  logic            is_lbu_i,
  input  logic            is_lhu_i,
  input  logic [1:0]      off_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{off_i, 3'b000} +: 8];
  assign half_sel = word_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    result_o = word_i;
    if (is_lb_i) begin
      result_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
    end else if (is_lbu_i) begin
      result_o = {{(XLEN-8){1'b0}}, byte_sel};
    end else if (is_lh_i) begin
      result_o = {{(XLEN-16){half_sel[15]}}, half_sel};
    end else if (is_lhu_i) begin
      result_o = {{(XLEN-16){1'b0}}, half_sel};
    end
  end

endmodule

// File: rtl/writer.sv
// Writeback stage: selects the writeback value for the instruction coming
// out of execute, commits it into the architectural register file, keeps a
// one-entry forward register for the executer and counts retirements.
//   CLK, RSTN        : clock, asynchronous active-low reset
//   WRITER_ENABLED   : stage advance enable; low = every register holds
//   CTR_INFO         : control word of the instruction in writeback
//   EXEC_RD          : ALU result
//   MEMORY_OUT       : block-memory read word
//   REGISTER_FILE    : architectural registers, entry 0 is constant zero
//   FORWARDED_VAL    : value chosen on the last enabled cycle
//   FORWARD_RD       : destination of FORWARDED_VAL, 0 = nothing to forward
//   RETIRED_COUNT    : valid instructions retired, wraps
module writer
  import writer_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       WRITER_ENABLED,
  input  control_info_t              CTR_INFO,
  input  logic [XLEN-1:0]            EXEC_RD,
  input  logic [XLEN-1:0]            MEMORY_OUT,
  output logic [NREG-1:0][XLEN-1:0]  REGISTER_FILE,
  output logic [XLEN-1:0]            FORWARDED_VAL,
  output logic [4:0]                 FORWARD_RD,
  output logic [CNT_W-1:0]           RETIRED_COUNT
);

  logic [XLEN-1:0]  load_val;
  logic [XLEN-1:0]  result_d;
  logic             commit_en;
  logic [XLEN-1:0]  fwd_val_q;
  logic [4:0]       fwd_rd_q;
  logic [CNT_W-1:0] cnt_q;

  load_formatter #(.XLEN(XLEN)) u_fmt (
    .word_i   (MEMORY_OUT),
    .is_lb_i  (CTR_INFO.op == OP_LB),
    .is_lh_i  (CTR_INFO.op == OP_LH),
    .is_lbu_i (CTR_INFO.op == OP_LBU),
    .is_lhu_i (CTR_INFO.op == OP_LHU),
    .off_i    (CTR_INFO.mem_byte_off),
    .result_o (load_val)
  );

  always_comb begin
    result_d = EXEC_RD;
    if (is_load(CTR_INFO.op)) begin
      result_d = load_val;
    end else if ((CTR_INFO.op == OP_JAL) || (CTR_INFO.op == OP_JALR)) begin
      // PC is word addressed, so the link is simply the next word.
      result_d = XLEN'(CTR_INFO.pc) + XLEN'(1);
    end
  end

  // A real architectural write: enabled, valid, writes rd, and rd is not x0.
  assign commit_en = WRITER_ENABLED && CTR_INFO.valid && CTR_INFO.write_rd &&
                     (CTR_INFO.rd != 5'd0);

  // x0 is a constant, never a storage element.
  assign REGISTER_FILE[0] = '0;

  // Discrete registers rather than a RAM: the whole file is visible on the
  // ports and is cleared asynchronously.
  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_rf
      logic [XLEN-1:0] entry_q;
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          entry_q <= '0;
        end else if (commit_en && (CTR_INFO.rd == 5'(gi))) begin
          entry_q <= result_d;
        end
      end
      assign REGISTER_FILE[gi] = entry_q;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fwd_val_q <= '0;
      fwd_rd_q  <= '0;
      cnt_q     <= '0;
    end else if (WRITER_ENABLED) begin
      // Loaded every enabled cycle; FORWARD_RD=0 marks it as meaningless.
      fwd_val_q <= result_d;
      fwd_rd_q  <= commit_en ? CTR_INFO.rd : 5'd0;
      if (CTR_INFO.valid) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign FORWARDED_VAL = fwd_val_q;
  assign FORWARD_RD    = fwd_rd_q;
  assign RETIRED_COUNT = cnt_q;

endmodule

// File: tb/tb_writer.sv
module tb_writer;
  import writer_pkg::*;

  logic                   CLK = 1'b0;
  logic                   RSTN = 1'b1;
  logic                   WRITER_ENABLED = 1'b0;
  control_info_t          CTR_INFO = '0;
  logic [31:0]            EXEC_RD = '0;
  logic [31:0]            MEMORY_OUT = '0;
  logic [31:0][31:0]      REGISTER_FILE;
  logic [31:0]            FORWARDED_VAL;
  logic [4:0]             FORWARD_RD;
  logic [31:0]            RETIRED_COUNT;

  // Narrow-counter build sharing the same stimulus; only its counter is used.
  logic [31:0][31:0]      rf4;
  logic [31:0]            fval4;
  logic [4:0]             frd4;
  logic [3:0]             cnt4;

  always #5 CLK = ~CLK;

  writer dut (
    .CLK(CLK), .RSTN(RSTN), .WRITER_ENABLED(WRITER_ENABLED),
    .CTR_INFO(CTR_INFO), .EXEC_RD(EXEC_RD), .MEMORY_OUT(MEMORY_OUT),
    .REGISTER_FILE(REGISTER_FILE), .FORWARDED_VAL(FORWARDED_VAL),
    .FORWARD_RD(FORWARD_RD), .RETIRED_COUNT(RETIRED_COUNT)
  );

  writer #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RSTN(RSTN), .WRITER_ENABLED(WRITER_ENABLED),
    .CTR_INFO(CTR_INFO), .EXEC_RD(EXEC_RD), .MEMORY_OUT(MEMORY_OUT),
    .REGISTER_FILE(rf4), .FORWARDED_VAL(fval4),
    .FORWARD_RD(frd4), .RETIRED_COUNT(cnt4)
  );

  // Reference model state
  logic [31:0] m_rf [32];
  logic [31:0] m_fval;
  logic [4:0]  m_frd;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_fval = '0;
    m_frd  = '0;
    m_cnt  = '0;
    m_cnt4 = '0;
  endtask

  // Writeback value straight from the instruction-level rules.
  function automatic logic [31:0] ref_result(input control_info_t c,
                                             input logic [31:0] ex,
                                             input logic [31:0] mem);
    int unsigned b, h;
    b = (mem >> (8 * c.mem_byte_off)) & 32'hFF;
    h = (mem >> (16 * (c.mem_byte_off / 2))) & 32'hFFFF;
    case (c.op)
      OP_LB:   return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      OP_LHU:  return h;
      OP_LW:   return mem;
      OP_JAL, OP_JALR: return c.pc + 1;
      default: return ex;
    endcase
  endfunction

  function automatic control_info_t mk(input logic v, input logic w, input int rd,
                                       input op_t op, input logic [31:0] pc,
                                       input int off);
    control_info_t c;
    c.valid = v;
    c.write_rd = w;
    c.rd = 5'(rd);
    c.op = op;
    c.pc = pc;
    c.mem_byte_off = 2'(off);
    return c;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s.x%0d", tag, i), REGISTER_FILE[i], m_rf[i]);
    chk({tag, ".fwd_val"}, FORWARDED_VAL, m_fval);
    chk({tag, ".fwd_rd"}, {27'b0, FORWARD_RD}, {27'b0, m_frd});
    chk({tag, ".retired"}, RETIRED_COUNT, m_cnt);
    chk({tag, ".retired4"}, {28'b0, cnt4}, {28'b0, m_cnt4});
  endtask

  // One clock of stimulus; inputs are applied away from the edge and the
  // outputs are sampled 1 time unit after it.
  task automatic step(input string tag, input logic en, input control_info_t c,
                      input logic [31:0] ex, input logic [31:0] mem);
    logic [31:0] r;
    WRITER_ENABLED = en;
    CTR_INFO = c;
    EXEC_RD = ex;
    MEMORY_OUT = mem;
    r = ref_result(c, ex, mem);
    @(posedge CLK);
    #1;
    if (en) begin
      m_fval = r;
      if (c.valid && c.write_rd && c.rd != 0) begin
        m_rf[c.rd] = r;
        m_frd = c.rd;
      end else begin
        m_frd = 0;
      end
      if (c.valid) begin
        m_cnt++;
        m_cnt4++;
      end
    end
    $display("txn %s en=%0b v=%0b w=%0b rd=%0d op=%0d off=%0d -> fwd=%h/%0d cnt=%0d",
             tag, en, c.valid, c.write_rd, c.rd, c.op, c.mem_byte_off,
             FORWARDED_VAL, FORWARD_RD, RETIRED_COUNT);
    check_all(tag);
  endtask

  op_t         ld_op  [6] = '{OP_LB, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  int          ld_off [6] = '{1, 3, 2, 2, 0, 1};
  logic [31:0] ld_exp [6] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00FF,
                              32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

  initial begin
    control_info_t c;

    // Power-up reset
    model_reset();
    #1 RSTN = 1'b0;
    #1 check_all("reset");
    @(negedge CLK);
    RSTN = 1'b1;

    // ALU writeback
    step("alu", 1'b1, mk(1, 1, 3, OP_ALU, 32'h0, 0), 32'h42, 32'h0);
    chk("alu.x3", REGISTER_FILE[3], 32'h42);
    chk("alu.fwd_val", FORWARDED_VAL, 32'h42);
    chk("alu.fwd_rd", {27'b0, FORWARD_RD}, 32'd3);
    chk("alu.retired", RETIRED_COUNT, 32'd1);

    // Load formatting
    for (int i = 0; i < 6; i++) begin
      step($sformatf("load%0d", i), 1'b1, mk(1, 1, 10 + i, ld_op[i], 32'h0, ld_off[i]),
           32'h5555_5555, 32'h80FF_7F01);
      chk($sformatf("load%0d.lit", i), REGISTER_FILE[10 + i], ld_exp[i]);
    end

    // x0 protection
    step("x0", 1'b1, mk(1, 1, 0, OP_ALU, 32'h0, 0), 32'h1234, 32'h0);
    chk("x0.lit", REGISTER_FILE[0], 32'h0);
    chk("x0.fwd_rd", {27'b0, FORWARD_RD}, 32'd0);
    chk("x0.retired", RETIRED_COUNT, 32'd8);

    // jal link
    step("jal", 1'b1, mk(1, 1, 1, OP_JAL, 32'h10, 0), 32'hAAAA_AAAA, 32'h0);
    chk("jal.x1", REGISTER_FILE[1], 32'h11);

    // Stall: a valid writing instruction is present but the stage is held
    for (int i = 0; i < 3; i++)
      step("stall", 1'b0, mk(1, 1, 20, OP_ALU, 32'h0, 0), 32'hCAFE_0000 + 32'(i), 32'h0);
    chk("stall.x20", REGISTER_FILE[20], 32'h0);

    // Bubble that claims to write x7
    step("bubble", 1'b1, mk(0, 1, 7, OP_ALU, 32'h0, 0), 32'h7777_7777, 32'h0);
    chk("bubble.x7", REGISTER_FILE[7], 32'h0);
    chk("bubble.fwd_rd", {27'b0, FORWARD_RD}, 32'd0);
    chk("bubble.retired", RETIRED_COUNT, 32'd9);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      c = mk($urandom_range(0, 99) < 85, 1'($urandom), $urandom_range(0, 31),
             op_t'(4'($urandom_range(0, 9))), $urandom, $urandom_range(0, 3));
      step("rand", $urandom_range(0, 99) < 80, c, $urandom, $urandom);
    end

    // Reset mid-run, asserted between clock edges
    step("pre_rst", 1'b1, mk(1, 1, 5, OP_ALU, 32'h0, 0), 32'hDEAD_BEEF, 32'h0);
    chk("pre_rst.x5", REGISTER_FILE[5], 32'hDEAD_BEEF);
    step("inflight", 1'b1, mk(1, 1, 6, OP_ALU, 32'h0, 0), 32'h6666_6666, 32'h0);
    #2 RSTN = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    chk("midrst.x5", REGISTER_FILE[5], 32'h0);
    @(negedge CLK);
    RSTN = 1'b1;

    // Counter wrap on the 4-bit build: 17 retires -> 1
    for (int i = 0; i < 17; i++)
      step("wrap", 1'b1, mk(1, 0, 0, OP_STORE, 32'h0, 0), $urandom, $urandom);
    chk("wrap.retired4", {28'b0, cnt4}, 32'd1);
    chk("wrap.retired", RETIRED_COUNT, 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/writer.md
Name: writer

Overview:
- Writeback stage, directly downstream of the executer.
- Consumes the executer's registered outputs: ALU result, block-memory read word, and the delayed control_info.
- Selects and formats the writeback value, then commits it to the architectural 32x32 register file that the executer reads.
- Also produces the registered FORWARDED_VAL fed back to the executer, and a retired-instruction counter.

Parameters:
- XLEN, 32, data width of registers and results
- NREG, 32, number of architectural registers; x0 is hardwired to zero
- CNT_W, 32, width of the retired-instruction counter

Ports:
- CLK  input  1  system clock, all state updates on the rising edge
- RSTN  input  1  asynchronous active-low reset
- WRITER_ENABLED  input  1  stage advance enable; when low, all state holds
- CTR_INFO  input  control_info  control word of the instruction in writeback (executer's CTR_INFO_OUT)
- EXEC_RD  input  XLEN  ALU result for the instruction
- MEMORY_OUT  input  XLEN  block-memory read word for the instruction
- REGISTER_FILE  output  XLEN x NREG  architectural register file contents, index 0..31
- FORWARDED_VAL  output  XLEN  last committed writeback value
- FORWARD_RD  output  5  destination index of FORWARDED_VAL; 0 means nothing to forward
- RETIRED_COUNT  output  CNT_W  number of instructions retired

Behaviour:
- Reset (RSTN low, asynchronous) clears all of the following to 0, immediately and independent of CLK:
  - every REGISTER_FILE entry
  - FORWARDED_VAL
  - FORWARD_RD
  - RETIRED_COUNT
- A reset asserted mid-operation discards any in-flight writeback.
- Input alignment: all three data inputs are registered one cycle after execute, so they are sampled together. No extra input registering.
- Result select (combinational):
  - Load op (lb, lh, lw, lbu, lhu) -> formatted MEMORY_OUT.
  - jal or jalr -> CTR_INFO.pc + 1 (word-addressed PC, link = next instruction).
  - Otherwise -> EXEC_RD.
- Load formatting uses CTR_INFO.mem_byte_off[1:0]:
  - lb / lbu: byte at bits [8*off+7 : 8*off]; lb sign-extends, lbu zero-extends.
  - lh / lhu: half at bits [16*off[1]+15 : 16*off[1]]; lh sign-extends, lhu zero-extends. off[0] is ignored (misaligned access is not trapped).
  - lw: full word; offset is ignored.
- Commit on rising CLK with WRITER_ENABLED=1 and CTR_INFO.write_rd=1:
  - REGISTER_FILE[rd] <= result when rd != 0.
  - rd == 0: no write; x0 always reads 0.
- Forward registers, on every enabled cycle:
  - FORWARDED_VAL <= result.
  - FORWARD_RD <= (write_rd && rd != 0) ? rd : 0.
  - With write_rd=0: FORWARD_RD becomes 0 and FORWARDED_VAL is don't-care (it is still loaded).
- Disabled cycle: REGISTER_FILE, FORWARDED_VAL, FORWARD_RD and RETIRED_COUNT all hold.
- Retire counter:
  - Increments on every enabled cycle where CTR_INFO.valid=1; bubbles do not count.
  - Wraps modulo 2^CNT_W.
- Validity gating: CTR_INFO.valid=0 suppresses the register write and forces FORWARD_RD to 0.
- Latency: a value is visible on REGISTER_FILE and FORWARDED_VAL in the cycle after the commit edge.
- Same-cycle read/write: the executer reading REGISTER_FILE[rd] in the commit cycle sees the old value and must rely on forwarding. The register file has no internal bypass.
- Stores and branches have write_rd=0: they only retire.

Decomposition:
- Shared package def.sv; the control_info struct gains these fields:
  - valid
  - write_rd
  - mem_byte_off[1:0] (populated by the executer from the low address bits)
- No new constants beyond these fields.
- One sub-module: load_formatter — pure combinational lane-select and extension. Inputs: the word, the load-op flags and the offset. Output: XLEN result.
- The register-file array, forward registers and counter stay in writer.

Test Plan:
- Reset mid-run:
  - Setup: write x5=0xDEADBEEF, then assert RSTN=0 between edges.
  - Response: x5, FORWARDED_VAL, FORWARD_RD and RETIRED_COUNT read 0 immediately, without a clock edge.
- ALU writeback:
  - Stimulus: valid, write_rd, rd=3, EXEC_RD=0x00000042, enabled.
  - Response: next cycle x3=0x42, FORWARDED_VAL=0x42, FORWARD_RD=3, RETIRED_COUNT=1.
- Load formatting, MEMORY_OUT=0x80FF7F01:
  - lb, off=1 -> 0x0000007F
  - lb, off=3 -> 0xFFFFFF80
  - lbu, off=2 -> 0x000000FF
  - lh, off=2 -> 0xFFFF80FF
  - lhu, off=0 -> 0x00007F01
  - lw -> 0x80FF7F01
- x0 protection:
  - Stimulus: write_rd, rd=0, EXEC_RD=0x1234.
  - Response: x0 stays 0, FORWARD_RD=0, RETIRED_COUNT increments.
- jal link:
  - Stimulus: jal, pc=0x10, rd=1.
  - Response: x1=0x11.
- Stall and bubble:
  - WRITER_ENABLED=0 for 3 cycles with a valid writing instruction present -> no state change.
  - valid=0 with write_rd=1, rd=7 -> x7 unchanged, counter unchanged.
- Counter wrap (CNT_W=4 build):
  - Stimulus: 17 valid retires.
  - Response: RETIRED_COUNT=1.
